clk_oe_sequencer: RTL



---
 rtl/clk_oe_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_oe_sequencer.sv
// Sequences the active-low PLD clock and CPU BCLK5 buffer enables on and off behind main VR / PCH power-good.
// Latency: PLD_DLY edges to PLD OE, +BCLK_DLY to BCLK5 OE. No backpressure; pwrok is a level input.
module clk_oe_sequencer #(
    parameter logic [15:0] PLD_DLY  = 16'd4,
    parameter logic [15:0] BCLK_DLY = 16'd3,
    parameter logic [15:0] OFF_DLY  = 16'd2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iMainVRPwrgd,
    input  logic       PWRGD_PCH_PWROK,
    input  logic       iMCP_EN_CLK,
    output logic       FM_PLD_CLKS_OE_N,
    output logic       FM_CPU_BCLK5_OE_N,
    output logic       oClkSeqDone,
    output logic       oClkSeqFault,
    output logic [2:0] oState
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PLD_WAIT  = 3'd1,
        ST_BCLK_WAIT = 3'd2,
        ST_ON        = 3'd3,
        ST_BCLK_OFF  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pld_oe_n_q, pld_oe_n_d;
    logic        bclk_oe_n_q, bclk_oe_n_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        pwrok;

    assign pwrok = iMainVRPwrgd && PWRGD_PCH_PWROK;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= 16'd0;
            pld_oe_n_q  <= 1'b1;
            bclk_oe_n_q <= 1'b1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pld_oe_n_q  <= pld_oe_n_d;
            bclk_oe_n_q <= bclk_oe_n_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pld_oe_n_d  = pld_oe_n_q;
        bclk_oe_n_d = bclk_oe_n_q;
        fault_d     = fault_q;
        case (state_q)
            ST_OFF: begin
                pld_oe_n_d  = 1'b1;
                bclk_oe_n_d = 1'b1;
                if (pwrok) begin
                    state_d = ST_PLD_WAIT;
                    cnt_d   = PLD_DLY - 16'd1;
                    fault_d = 1'b0;
                end
            end
            ST_PLD_WAIT: begin
                if (!pwrok) begin
                    state_d = ST_OFF;
                    fault_d = 1'b1;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d    = ST_BCLK_WAIT;
                    pld_oe_n_d = 1'b0;
                    cnt_d      = BCLK_DLY - 16'd1;
                end
            end
            ST_BCLK_WAIT: begin
                if (!pwrok) begin
                    state_d     = ST_BCLK_OFF;
                    fault_d     = 1'b1;
                    bclk_oe_n_d = 1'b1;
                    cnt_d       = OFF_DLY - 16'd1;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d     = ST_ON;
                    bclk_oe_n_d = !iMCP_EN_CLK;
                end
            end
            ST_ON: begin
                bclk_oe_n_d = !iMCP_EN_CLK;
                // Orderly power loss after full sequencing is not a fault.
                if (!pwrok) begin
                    state_d     = ST_BCLK_OFF;
                    bclk_oe_n_d = 1'b1;
                    cnt_d       = OFF_DLY - 16'd1;
                end
            end
            ST_BCLK_OFF: begin
                bclk_oe_n_d = 1'b1;
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d    = ST_OFF;
                    pld_oe_n_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_OFF;
                pld_oe_n_d  = 1'b1;
                bclk_oe_n_d = 1'b1;
            end
        endcase
        done_d = (state_d == ST_ON);
    end

    assign FM_PLD_CLKS_OE_N  = pld_oe_n_q;
    assign FM_CPU_BCLK5_OE_N = bclk_oe_n_q;
    assign oClkSeqDone       = done_q;
    assign oClkSeqFault      = fault_q;
    assign oState            = state_q;

endmodule
